// File: rtl/chip8_cpu_sequencer_pkg.sv
// Shared types and opcode constants for the Chip-8 fetch/execute sequencer.
package chip8_cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_HI  = 3'd1,
    F_LO  = 3'd2,
    F_CAP = 3'd3,
    EXEC  = 3'd4,
    MULTI = 3'd5
  } seq_state_t;

  localparam logic [7:0]  OP_FX33 = 8'h33;
  localparam logic [7:0]  OP_FX55 = 8'h55;
  localparam logic [7:0]  OP_FX65 = 8'h65;
  localparam logic [7:0]  OP_FX0A = 8'h0A;
  localparam logic [11:0] RESET_PC_DEFAULT = 12'h200;

  // Last control step of an instruction; 0 means a single exec cycle.
  function automatic logic [3:0] step_limit(input logic [15:0] instr);
    logic [3:0] lim;
    lim = 4'd0;
    if (instr[15:12] == 4'hF) begin
      case (instr[7:0])
        OP_FX55, OP_FX65: lim = instr[11:8];
        OP_FX33:          lim = 4'd2;
        default:          lim = 4'd0;
      endcase
    end else begin
      lim = 4'd0;
    end
    return lim;
  endfunction

  function automatic logic is_key_wait(input logic [15:0] instr);
    return (instr[15:12] == 4'hF) && (instr[7:0] == OP_FX0A);
  endfunction

endpackage

// File: rtl/chip8_cpu_sequencer_if.sv
// Program-memory fetch port and datapath handshake of the sequencer.
interface chip8_cpu_sequencer_if;

  logic [11:0] fetch_addr;
  logic        fetch_re;
  logic [7:0]  fetch_data;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [3:0]  control;
  logic [11:0] pc;
  logic        dp_pc_we;
  logic [11:0] dp_pc_wdata;
  logic        dp_skip;

  modport master (
    output fetch_addr, fetch_re, instruction, instr_valid, control, pc,
    input  fetch_data, dp_pc_we, dp_pc_wdata, dp_skip
  );

  modport slave (
    input  fetch_addr, fetch_re, instruction, instr_valid, control, pc,
    output fetch_data, dp_pc_we, dp_pc_wdata, dp_skip
  );

endinterface

// File: rtl/chip8_cpu_sequencer_tick_divider.sv
// Free-running divider producing the 60 Hz delay/sound timer tick.
module chip8_tick_divider #(
  parameter int TICK_DIV = 833333
) (
  input  logic cpu_clk,
  input  logic cpu_rst_n,
  output logic timer_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  assign cnt_d      = (cnt_q == CNT_MAX) ? CNT_W'(0) : cnt_q + CNT_W'(1);
  assign timer_tick = tick_q;

  // Tick is registered so it is high exactly while the count sits at its top value.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_q  <= CNT_W'(0);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_MAX);
    end
  end

endmodule

// File: rtl/chip8_cpu_sequencer.sv
// Chip-8 fetch/execute sequencer: fetches 2-byte opcodes, steps multicycle ops, commits PC.
module chip8_cpu_sequencer
  import chip8_cpu_sequencer_pkg::*;
#(
  parameter logic [11:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TICK_DIV = 833333
) (
  input  logic                    cpu_clk,
  input  logic                    cpu_rst_n,
  input  logic                    run,
  input  logic                    key_valid,
  output logic                    timer_tick,
  output logic                    busy,
  chip8_cpu_sequencer_if.master   bus
);

  seq_state_t  state_q, state_d, resume_state_s;
  logic [11:0] pc_q, pc_d, commit_pc_s;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  hi_q, hi_d;
  logic [3:0]  step_q, step_d, limit_s;
  logic [11:0] fetch_addr_q, fetch_addr_d;
  logic        fetch_re_q, fetch_re_d;
  logic        instr_valid_q, instr_valid_d;
  logic        busy_q, busy_d;
  logic        key_wait_s, last_s;

  chip8_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .cpu_clk    (cpu_clk),
    .cpu_rst_n  (cpu_rst_n),
    .timer_tick (timer_tick)
  );

  assign limit_s        = step_limit(instr_q);
  assign key_wait_s     = is_key_wait(instr_q);
  assign last_s         = ((state_q == EXEC) && (key_wait_s ? key_valid : (limit_s == 4'd0)))
                       || ((state_q == MULTI) && (step_q == limit_s));
  assign commit_pc_s    = bus.dp_pc_we ? bus.dp_pc_wdata
                        : (bus.dp_skip ? pc_q + 12'd4 : pc_q + 12'd2);
  assign resume_state_s = run ? F_HI : IDLE;

  // Next-state, instruction capture, step counter and PC commit.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    hi_d    = hi_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = F_HI;
          pc_d    = RESET_PC;
        end else begin
          state_d = IDLE;
        end
      end
      F_HI:  state_d = F_LO;
      F_LO: begin
        hi_d    = bus.fetch_data;
        state_d = F_CAP;
      end
      F_CAP: begin
        instr_d = {hi_q, bus.fetch_data};
        state_d = EXEC;
      end
      EXEC: begin
        if (last_s) begin
          state_d = resume_state_s;
          pc_d    = commit_pc_s;
          step_d  = 4'd0;
        end else if (key_wait_s) begin
          state_d = EXEC;
        end else begin
          state_d = MULTI;
          step_d  = 4'd1;
        end
      end
      MULTI: begin
        if (last_s) begin
          state_d = resume_state_s;
          pc_d    = commit_pc_s;
          step_d  = 4'd0;
        end else begin
          step_d  = step_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 4'd0;
      end
    endcase
  end

  // Output registers are loaded from the next state so they line up with it.
  always_comb begin
    fetch_re_d    = (state_d == F_HI) || (state_d == F_LO);
    instr_valid_d = (state_d == EXEC) || (state_d == MULTI);
    busy_d        = (state_d != IDLE);
    if (state_d == F_HI) begin
      fetch_addr_d = pc_d;
    end else if (state_d == F_LO) begin
      fetch_addr_d = pc_q + 12'd1;
    end else begin
      fetch_addr_d = fetch_addr_q;
    end
  end

  // Sequencer state; reset aborts any in-flight instruction without a PC commit.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      hi_q          <= 8'h00;
      step_q        <= 4'd0;
      fetch_addr_q  <= 12'h000;
      fetch_re_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      hi_q          <= hi_d;
      step_q        <= step_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_re_q    <= fetch_re_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.fetch_re    = fetch_re_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.control     = step_q;
  assign bus.pc          = pc_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_chip8_cpu_sequencer.sv
// Directed self-checking bench for chip8_cpu_sequencer with a synchronous byte memory model.
module tb_chip8_cpu_sequencer;

  logic clk;
  logic rst_n;
  logic run;
  logic key_valid;
  logic timer_tick;
  logic busy;
  logic [7:0] mem [0:4095];
  int checks;
  int errors;

  chip8_cpu_sequencer_if bus_if ();

  chip8_cpu_sequencer #(.RESET_PC(12'h200), .TICK_DIV(4)) dut (
    .cpu_clk    (clk),
    .cpu_rst_n  (rst_n),
    .run        (run),
    .key_valid  (key_valid),
    .timer_tick (timer_tick),
    .busy       (busy),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus_if.fetch_re) bus_if.fetch_data <= mem[bus_if.fetch_addr];
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, " busy"},        {31'd0, busy},               32'd0);
    check_value({tag, " pc"},          {20'd0, bus_if.pc},          32'h200);
    check_value({tag, " instruction"}, {16'd0, bus_if.instruction}, 32'h0000);
    check_value({tag, " instr_valid"}, {31'd0, bus_if.instr_valid}, 32'd0);
    check_value({tag, " control"},     {28'd0, bus_if.control},     32'd0);
    check_value({tag, " fetch_re"},    {31'd0, bus_if.fetch_re},    32'd0);
    check_value({tag, " fetch_addr"},  {20'd0, bus_if.fetch_addr},  32'h000);
    check_value({tag, " timer_tick"},  {31'd0, timer_tick},         32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    key_valid = 1'b0;
    bus_if.dp_pc_we = 1'b0;
    bus_if.dp_pc_wdata = 12'h000;
    bus_if.dp_skip = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  // Called at the negedge where F_HI is visible; returns at the first exec negedge.
  task automatic fetch_check(input logic [11:0] addr, input logic [15:0] instr);
    logic [11:0] next_addr;
    next_addr = addr + 12'd1;
    check_value("fhi_re",   {31'd0, bus_if.fetch_re},   32'd1);
    check_value("fhi_addr", {20'd0, bus_if.fetch_addr}, {20'd0, addr});
    step();
    check_value("flo_addr", {20'd0, bus_if.fetch_addr}, {20'd0, next_addr});
    step();
    check_value("fcap_re",  {31'd0, bus_if.fetch_re},   32'd0);
    step();
    check_value("exec_instr", {16'd0, bus_if.instruction}, {16'd0, instr});
    check_value("exec_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    check_value("exec_ctrl0", {28'd0, bus_if.control},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    run = 1'b0;
    key_valid = 1'b0;
    bus_if.dp_pc_we = 1'b0;
    bus_if.dp_pc_wdata = 12'h000;
    bus_if.dp_skip = 1'b0;

    // 1) basic single-cycle instruction
    do_reset();
    mem[12'h200] = 8'h6A; mem[12'h201] = 8'h05;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'h6A05);
    step();
    check_value("t1_pc",        {20'd0, bus_if.pc},          32'h202);
    check_value("t1_next_addr", {20'd0, bus_if.fetch_addr},  32'h202);
    check_value("t1_hold_ir",   {16'd0, bus_if.instruction}, 32'h6A05);
    check_value("t1_valid_off", {31'd0, bus_if.instr_valid}, 32'd0);

    // 2) datapath PC write, skip, and write-over-skip priority
    do_reset();
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    bus_if.dp_pc_we = 1'b1; bus_if.dp_pc_wdata = 12'h234;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'h1234);
    step();
    check_value("t2_jump_addr", {20'd0, bus_if.fetch_addr}, 32'h234);
    do_reset();
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    bus_if.dp_skip = 1'b1;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'h1234);
    step();
    check_value("t2_skip_pc", {20'd0, bus_if.pc}, 32'h204);
    bus_if.dp_pc_we = 1'b1; bus_if.dp_pc_wdata = 12'h300;
    fetch_check(12'h204, 16'h0000);
    step();
    check_value("t2_we_over_skip", {20'd0, bus_if.pc}, 32'h300);

    // 3) multicycle F355, F033, F165, F055
    do_reset();
    mem[12'h200] = 8'hF3; mem[12'h201] = 8'h55;
    mem[12'h202] = 8'hF0; mem[12'h203] = 8'h33;
    mem[12'h204] = 8'hF1; mem[12'h205] = 8'h65;
    mem[12'h206] = 8'hF0; mem[12'h207] = 8'h55;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'hF355);
    for (int s = 1; s <= 3; s++) begin
      step();
      check_value("t3_f355_ctrl",  {28'd0, bus_if.control},     s);
      check_value("t3_f355_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    end
    step();
    check_value("t3_f355_pc",  {20'd0, bus_if.pc},          32'h202);
    check_value("t3_f355_end", {31'd0, bus_if.instr_valid}, 32'd0);
    fetch_check(12'h202, 16'hF033);
    for (int s = 1; s <= 2; s++) begin
      step();
      check_value("t3_f033_ctrl", {28'd0, bus_if.control}, s);
    end
    step();
    check_value("t3_f033_pc", {20'd0, bus_if.pc}, 32'h204);
    fetch_check(12'h204, 16'hF165);
    step();
    check_value("t3_f165_ctrl", {28'd0, bus_if.control}, 32'd1);
    step();
    check_value("t3_f165_pc", {20'd0, bus_if.pc}, 32'h206);
    fetch_check(12'h206, 16'hF055);
    step();
    check_value("t3_f055_pc", {20'd0, bus_if.pc}, 32'h208);

    // 4) key wait with run dropped during the wait
    do_reset();
    mem[12'h200] = 8'hF5; mem[12'h201] = 8'h0A;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'hF50A);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_value("t4_wait_valid", {31'd0, bus_if.instr_valid}, 32'd1);
      check_value("t4_wait_pc",    {20'd0, bus_if.pc},          32'h200);
    end
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check_value("t4_key_pc",   {20'd0, bus_if.pc}, 32'h202);
    check_value("t4_idle_busy", {31'd0, busy},     32'd0);
    step();
    check_value("t4_idle_re", {31'd0, bus_if.fetch_re}, 32'd0);

    // 5) PC wrap at the top of memory
    do_reset();
    mem[12'h200] = 8'h1F; mem[12'h201] = 8'hFE;
    mem[12'hFFE] = 8'h00; mem[12'hFFF] = 8'hA1;
    bus_if.dp_pc_we = 1'b1; bus_if.dp_pc_wdata = 12'hFFE;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'h1FFE);
    step();
    bus_if.dp_pc_we = 1'b0;
    fetch_check(12'hFFE, 16'h00A1);
    step();
    check_value("t5_wrap_pc", {20'd0, bus_if.pc}, 32'h000);
    do_reset();
    mem[12'h200] = 8'h1F; mem[12'h201] = 8'hFF;
    mem[12'hFFF] = 8'hA1; mem[12'h000] = 8'h23;
    bus_if.dp_pc_we = 1'b1; bus_if.dp_pc_wdata = 12'hFFF;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'h1FFF);
    step();
    bus_if.dp_pc_we = 1'b0;
    fetch_check(12'hFFF, 16'hA123);
    step();
    check_value("t5_odd_wrap_pc", {20'd0, bus_if.pc}, 32'h001);

    // 6) timer tick period, then asynchronous reset in the middle of F355
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      check_value("t6_tick", {31'd0, timer_tick}, {31'd0, (k % 4) == 3});
    end
    do_reset();
    mem[12'h200] = 8'hF3; mem[12'h201] = 8'h55;
    run = 1'b1;
    step();
    fetch_check(12'h200, 16'hF355);
    step();
    check_value("t6_mid_ctrl", {28'd0, bus_if.control}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
